fft_bitrev_reorder: RTL and testbench

- Output reorder buffer that sits after the last R2²SDF butterfly stage of the FFT pipeline.
- The pipeline emits each N-point frame in bit-reversed bin order. This block buffers each frame and replays it in natural bin order (bin 0 … N-1).
- Uses ping-pong double buffering so a new frame can be written while the previous one is read out.
- The output side has a valid/ready handshake so downstream consumers can stall it.

---
 rtl/fft_bitrev_reorder.sv | 150 +++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT frames into natural bin order using two ping-pong banks.
// The output side has a valid/ready handshake; a skid register absorbs the one-cycle read latency.
module fft_bitrev_reorder #(
  parameter int DATA_WIDTH = 25,
  parameter int FFT_N      = 1024,
  parameter int FFT_NLOG2  = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] x_re_i,
  input  logic [DATA_WIDTH-1:0] x_im_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] z_re_o,
  output logic [DATA_WIDTH-1:0] z_im_o,
  output logic [FFT_NLOG2-1:0]  idx_o,
  output logic                  last_o,
  output logic                  overflow_o
);

  localparam int                   WORD_W   = 2 * DATA_WIDTH;
  localparam logic [FFT_NLOG2-1:0] LAST_IDX = FFT_NLOG2'(FFT_N - 1);
  localparam logic [0:0]           S_IDLE   = 1'b0;
  localparam logic [0:0]           S_READ   = 1'b1;

  function automatic logic [FFT_NLOG2-1:0] bitrev(input logic [FFT_NLOG2-1:0] a);
    logic [FFT_NLOG2-1:0] r;
    for (int i = 0; i < FFT_NLOG2; i++) r[i] = a[FFT_NLOG2-1-i];
    return r;
  endfunction

  logic [WORD_W-1:0]    mem [2*FFT_N];
  logic [1:0]           bank_full, bank_full_nxt;

  logic [FFT_NLOG2-1:0] wr_cnt;
  logic                 wr_bank, wr_keep, wr_start, wr_en, wr_done;

  logic [FFT_NLOG2-1:0] rd_cnt;
  logic                 rd_bank, rd_issue, rd_wrap;
  logic [0:0]           state;

  logic [WORD_W-1:0]    mem_q, skid_q;
  logic [FFT_NLOG2-1:0] mem_idx, skid_idx;
  logic                 mem_vld, skid_vld, acc, out_load;
  logic [1:0]           occ;

  // A frame's fate (kept or dropped) is decided on its first sample and held for the rest.
  assign wr_start = valid_i && (wr_cnt == '0);
  assign wr_en    = valid_i && (wr_start ? !bank_full[wr_bank] : wr_keep);
  assign wr_done  = wr_en && (wr_cnt == LAST_IDX);

  // Words still owed downstream after this edge; a new read is issued only if it will fit.
  assign acc      = valid_o && ready_i;
  assign out_load = !valid_o || acc;
  assign occ      = 2'(valid_o) + 2'(skid_vld) + 2'(mem_vld) - 2'(acc);
  assign rd_issue = ((state == S_READ) || bank_full[rd_bank]) && (occ < 2'd2);
  assign rd_wrap  = rd_issue && (rd_cnt == LAST_IDX);

  // A bank is released as soon as its last word leaves the RAM; the pipeline holds the rest.
  always_comb begin
    // NOTE: defaulting every output of a combinational block first keeps it free of latches.
    bank_full_nxt = bank_full;
    if (wr_done) bank_full_nxt[wr_bank] = 1'b1;
    if (rd_wrap) bank_full_nxt[rd_bank] = 1'b0;
  end

  // NOTE: the storage array has no reset so it maps onto block RAM; the bank flags say what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en)    mem[{wr_bank, wr_cnt}] <= {x_re_i, x_im_i};
    if (rd_issue) mem_q <= mem[{rd_bank, bitrev(rd_cnt)}];
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    if (!rst_n) begin
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      wr_keep    <= 1'b0;
      overflow_o <= 1'b0;
      bank_full  <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      if (valid_i) wr_cnt <= wr_cnt + 1'b1;
      if (wr_start) begin
        wr_keep <= !bank_full[wr_bank];
        if (bank_full[wr_bank]) overflow_o <= 1'b1;
      end
      if (wr_done) wr_bank <= ~wr_bank;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
      state   <= S_IDLE;
    end else if (rd_issue) begin
      rd_cnt <= rd_cnt + 1'b1;
      if (rd_wrap) begin
        rd_bank <= ~rd_bank;
        state   <= bank_full[~rd_bank] ? S_READ : S_IDLE;
      end else begin
        state <= S_READ;
      end
    end
  end

  // Output register is refilled from the skid first, then straight from the RAM.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      mem_vld  <= 1'b0;
      mem_idx  <= '0;
      skid_vld <= 1'b0;
      skid_q   <= '0;
      skid_idx <= '0;
      valid_o  <= 1'b0;
      z_re_o   <= '0;
      z_im_o   <= '0;
      idx_o    <= '0;
      last_o   <= 1'b0;
    end else begin
      mem_vld <= rd_issue;
      if (rd_issue) mem_idx <= rd_cnt;
      if (out_load) begin
        if (skid_vld) begin
          valid_o            <= 1'b1;
          {z_re_o, z_im_o}   <= skid_q;
          idx_o              <= skid_idx;
          last_o             <= (skid_idx == LAST_IDX);
          skid_vld           <= mem_vld;
          skid_q             <= mem_q;
          skid_idx           <= mem_idx;
        end else begin
          valid_o <= mem_vld;
          if (mem_vld) begin
            {z_re_o, z_im_o} <= mem_q;
            idx_o            <= mem_idx;
            last_o           <= (mem_idx == LAST_IDX);
          end
        end
      end else if (mem_vld) begin
        skid_vld <= 1'b1;
        skid_q   <= mem_q;
        skid_idx <= mem_idx;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: an 8-point instance for the corner cases and a 1024-point
// instance for the default size, both scored against a queue of natural-order expectations.
module tb_fft_bitrev_reorder;

  localparam int DW = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          v8_i, rdy8, v8_o, last8_o, ovf8_o;
  logic [DW-1:0] re8_i, im8_i, re8_o, im8_o;
  logic [2:0]    idx8_o;
  logic          v10_i, rdy10, v10_o, last10_o, ovf10_o;
  logic [DW-1:0] re10_i, im10_i, re10_o, im10_o;
  logic [9:0]    idx10_o;

  fft_bitrev_reorder #(.DATA_WIDTH(DW), .FFT_N(8), .FFT_NLOG2(3)) dut8 (
    .clk_i(clk), .rst_n(rst_n), .valid_i(v8_i), .x_re_i(re8_i), .x_im_i(im8_i),
    .ready_i(rdy8), .valid_o(v8_o), .z_re_o(re8_o), .z_im_o(im8_o), .idx_o(idx8_o),
    .last_o(last8_o), .overflow_o(ovf8_o));

  fft_bitrev_reorder #(.DATA_WIDTH(DW), .FFT_N(1024), .FFT_NLOG2(10)) dut1024 (
    .clk_i(clk), .rst_n(rst_n), .valid_i(v10_i), .x_re_i(re10_i), .x_im_i(im10_i),
    .ready_i(rdy10), .valid_o(v10_o), .z_re_o(re10_o), .z_im_o(im10_o), .idx_o(idx10_o),
    .last_o(last10_o), .overflow_o(ovf10_o));

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    int            idx;
    bit            last;
  } exp_t;

  typedef struct {
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic [DW-1:0] exp_re;
    logic [DW-1:0] exp_im;
    int            exp_idx;
    bit            exp_last;
  } vec_t;

  exp_t          exp8[$], exp10[$];
  vec_t          tbl[8];
  logic [DW-1:0] fr_re8[8], fr_im8[8], fr_re10[1024], fr_im10[1024];
  int            order[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int            n_total = 0, n_pass = 0, cyc = 0;
  int            first8 = -1, last8 = -1, frames_done8 = 0;
  bit            ready_rand = 1'b0, hold_v = 1'b0;
  logic [63:0]   hold_val;

  function automatic int bitrev_ref(int k, int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) begin
      r = r * 2 + k % 2;
      k = k / 2;
    end
    return r;
  endfunction

  function automatic logic [63:0] pack(logic [DW-1:0] re, logic [DW-1:0] im, int idx, bit last);
    return {3'b000, re, im, idx[9:0], last};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Observes both outputs just before the edge that completes any handshake.
  task automatic monitor();
    exp_t e;
    if (v8_o && rdy8) begin
      if (exp8.size() == 0) check("extra_out8", 64'(v8_o), 64'(0));
      else begin
        e = exp8.pop_front();
        check("out8", pack(re8_o, im8_o, int'(idx8_o), last8_o), pack(e.re, e.im, e.idx, e.last));
        if (e.last) frames_done8++;
        if (first8 < 0) first8 = cyc;
        last8 = cyc;
      end
    end
    if (hold_v) begin
      check("stall_valid8", 64'(v8_o), 64'(1));
      check("stall_data8", pack(re8_o, im8_o, int'(idx8_o), last8_o), hold_val);
    end
    hold_v   = v8_o && !rdy8 && rst_n;
    hold_val = pack(re8_o, im8_o, int'(idx8_o), last8_o);
    if (v10_o && rdy10) begin
      if (exp10.size() == 0) check("extra_out10", 64'(v10_o), 64'(0));
      else begin
        e = exp10.pop_front();
        check("out10", pack(re10_o, im10_o, int'(idx10_o), last10_o), pack(e.re, e.im, e.idx, e.last));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (ready_rand) rdy8 = 1'($urandom_range(0, 1));
  endtask

  task automatic send8(logic [DW-1:0] re, logic [DW-1:0] im);
    v8_i  = 1'b1;
    re8_i = re;
    im8_i = im;
    step();
  endtask

  // Natural-order expectation: output bin k carries input sample bitrev(k).
  task automatic push_exp8();
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.re   = fr_re8[bitrev_ref(k, 3)];
      e.im   = fr_im8[bitrev_ref(k, 3)];
      e.idx  = k;
      e.last = (k == 7);
      exp8.push_back(e);
    end
  endtask

  task automatic send_frame8(bit gaps);
    for (int n = 0; n < 8; n++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) begin
        v8_i = 1'b0;
        step();
      end
      send8(fr_re8[n], fr_im8[n]);
    end
  endtask

  task automatic drain8(int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp8.size() == 0) break;
      step();
    end
    check("drain8", 64'(exp8.size()), 64'(0));
    exp8.delete();
    repeat (4) step();
  endtask

  initial begin
    rst_n = 1'b0; v8_i = 1'b0; re8_i = '0; im8_i = '0; rdy8 = 1'b1;
    v10_i = 1'b0; re10_i = '0; im10_i = '0; rdy10 = 1'b1;

    for (int n = 0; n < 8; n++) begin
      tbl[n].in_re    = DW'(n);
      tbl[n].in_im    = DW'(-n);
      tbl[n].exp_re   = DW'(order[n]);
      tbl[n].exp_im   = DW'(-order[n]);
      tbl[n].exp_idx  = n;
      tbl[n].exp_last = (n == 7);
    end

    // Reset state
    step();
    step();
    check("rst8_data", pack(re8_o, im8_o, int'(idx8_o), last8_o), 64'(0));
    check("rst8_flags", {v8_o, ovf8_o}, 64'(0));
    check("rst10_data", pack(re10_o, im10_o, int'(idx10_o), last10_o), 64'(0));
    check("rst10_flags", {v10_o, ovf10_o}, 64'(0));
    rst_n = 1'b1;
    step();

    // 1. Reorder one frame, table-driven, with latency check
    for (int n = 0; n < 8; n++) exp8.push_back('{tbl[n].exp_re, tbl[n].exp_im, tbl[n].exp_idx, tbl[n].exp_last});
    for (int n = 0; n < 8; n++) send8(tbl[n].in_re, tbl[n].in_im);
    v8_i = 1'b0;
    step();
    check("lat8_e1", 64'(v8_o), 64'(0));
    step();
    check("lat8_e2", 64'(v8_o), 64'(1));
    drain8(50);

    // 2. Four back-to-back frames, no bubbles
    first8 = -1;
    for (int f = 0; f < 4; f++) begin
      for (int n = 0; n < 8; n++) begin
        fr_re8[n] = DW'(f * 8 + n);
        fr_im8[n] = DW'(-(f * 8 + n));
      end
      push_exp8();
      send_frame8(1'b0);
    end
    v8_i = 1'b0;
    drain8(100);
    check("gaps8", 64'(last8 - first8 + 1), 64'(32));
    check("ovf8_s2", 64'(ovf8_o), 64'(0));

    // 3. Backpressure with pseudo-random ready
    for (int n = 0; n < 8; n++) exp8.push_back('{tbl[n].exp_re, tbl[n].exp_im, tbl[n].exp_idx, tbl[n].exp_last});
    ready_rand = 1'b1;
    for (int n = 0; n < 8; n++) send8(tbl[n].in_re, tbl[n].in_im);
    v8_i = 1'b0;
    drain8(200);
    ready_rand = 1'b0;
    rdy8 = 1'b1;

    // 4. Overflow: three frames into a stalled output
    rdy8 = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < 8; n++) begin
        fr_re8[n] = DW'(300 + f * 8 + n);
        fr_im8[n] = DW'(700 + f * 8 + n);
      end
      if (f < 2) begin
        push_exp8();
        send_frame8(1'b0);
      end else begin
        check("ovf8_pre", 64'(ovf8_o), 64'(0));
        send8(fr_re8[0], fr_im8[0]);
        check("ovf8_set", 64'(ovf8_o), 64'(1));
        for (int n = 1; n < 8; n++) send8(fr_re8[n], fr_im8[n]);
      end
    end
    v8_i = 1'b0;
    repeat (5) step();
    rdy8 = 1'b1;
    drain8(100);
    check("ovf8_sticky", 64'(ovf8_o), 64'(1));

    // 5. Reset on the 5th sample of frame 2 while frame 1 is being read
    for (int n = 0; n < 8; n++) begin
      fr_re8[n] = DW'(400 + n);
      fr_im8[n] = DW'(-(400 + n));
    end
    push_exp8();
    send_frame8(1'b0);
    for (int n = 0; n < 4; n++) send8(DW'(500 + n), DW'(0));
    rst_n = 1'b0;
    send8(DW'(504), DW'(0));
    rst_n = 1'b1;
    v8_i  = 1'b0;
    check("rst_valid8", 64'(v8_o), 64'(0));
    check("rst_ovf8", 64'(ovf8_o), 64'(0));
    exp8.delete();
    hold_v = 1'b0;
    for (int n = 0; n < 8; n++) begin
      fr_re8[n] = DW'(600 + n);
      fr_im8[n] = DW'(900 - n);
    end
    push_exp8();
    send_frame8(1'b0);
    v8_i = 1'b0;
    step();
    check("lat8r_e1", 64'(v8_o), 64'(0));
    step();
    check("lat8r_e2", 64'(v8_o), 64'(1));
    drain8(50);

    // Random frames with input gaps and random ready; a new frame starts only
    // once the frame two ahead of it has fully left, so nothing may be dropped.
    frames_done8 = 0;
    ready_rand   = 1'b1;
    for (int f = 0; f < 6; f++) begin
      if (f >= 2) begin
        for (int i = 0; i < 200; i++) begin
          if (frames_done8 >= f - 1) break;
          v8_i = 1'b0;
          step();
        end
        check("wait_frame8", 64'(frames_done8 >= f - 1), 64'(1));
      end
      for (int n = 0; n < 8; n++) begin
        fr_re8[n] = DW'($urandom);
        fr_im8[n] = DW'($urandom);
      end
      push_exp8();
      send_frame8(1'b1);
    end
    v8_i = 1'b0;
    drain8(400);
    ready_rand = 1'b0;
    rdy8 = 1'b1;
    check("ovf8_rand", 64'(ovf8_o), 64'(0));

    // 6. Default size: 1024 random samples
    for (int n = 0; n < 1024; n++) begin
      fr_re10[n] = DW'($urandom);
      fr_im10[n] = DW'($urandom);
    end
    for (int k = 0; k < 1024; k++)
      exp10.push_back('{fr_re10[bitrev_ref(k, 10)], fr_im10[bitrev_ref(k, 10)], k, k == 1023});
    for (int n = 0; n < 1024; n++) begin
      v10_i  = 1'b1;
      re10_i = fr_re10[n];
      im10_i = fr_im10[n];
      step();
    end
    v10_i = 1'b0;
    step();
    check("lat10_e1", 64'(v10_o), 64'(0));
    step();
    check("lat10_e2", 64'(v10_o), 64'(1));
    for (int i = 0; i < 1200; i++) begin
      if (exp10.size() == 0) break;
      step();
    end
    check("drain10", 64'(exp10.size()), 64'(0));
    repeat (4) step();
    check("ovf10", 64'(ovf10_o), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
